// File: rtl/spgd_metric_sequencer.sv
// Two-sided SPGD metric sequencer: measures J+ and J- through the ADC averager
// and emits the signed difference for the gradient-update stage.
module spgd_metric_sequencer #(
  parameter int ADC_WIDTH      = 12,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADC_WIDTH-1:0] avg_data,
  input  logic                 avg_done,
  output logic                 avg_clr,
  output logic                 pert_en,
  output logic                 pert_sign,
  output logic                 busy,
  output logic [ADC_WIDTH-1:0] j_plus,
  output logic [ADC_WIDTH-1:0] j_minus,
  output logic [ADC_WIDTH:0]   delta_j,
  output logic                 valid,
  output logic                 err
);

  typedef enum logic [2:0] {IDLE, SETTLE_P, AVG_P, SETTLE_M, AVG_M, CALC} state_t;

  // One shared counter serves both the settle countdown and the timeout count-up.
  localparam int CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 avg_done_d;
  logic                 avg_rise;
  logic                 avg_clr_n, pert_en_n, pert_sign_n, busy_n, valid_n, err_n;
  logic [ADC_WIDTH-1:0] j_plus_n, j_minus_n;
  logic [ADC_WIDTH:0]   delta_n;

  // A level already high when an averaging window opens is not a new result.
  assign avg_rise = avg_done & ~avg_done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      avg_done_d <= 1'b0;
      avg_clr    <= 1'b1;
      pert_en    <= 1'b0;
      pert_sign  <= 1'b0;
      busy       <= 1'b0;
      valid      <= 1'b0;
      err        <= 1'b0;
      j_plus     <= '0;
      j_minus    <= '0;
      delta_j    <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      avg_done_d <= avg_done;
      avg_clr    <= avg_clr_n;
      pert_en    <= pert_en_n;
      pert_sign  <= pert_sign_n;
      busy       <= busy_n;
      valid      <= valid_n;
      err        <= err_n;
      j_plus     <= j_plus_n;
      j_minus    <= j_minus_n;
      delta_j    <= delta_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    avg_clr_n   = avg_clr;
    pert_en_n   = pert_en;
    pert_sign_n = pert_sign;
    busy_n      = busy;
    valid_n     = 1'b0;
    err_n       = 1'b0;
    j_plus_n    = j_plus;
    j_minus_n   = j_minus;
    delta_n     = delta_j;

    case (state)
      IDLE: begin
        avg_clr_n = 1'b1;
        pert_en_n = 1'b0;
        busy_n    = 1'b0;
        if (start) begin
          state_n     = SETTLE_P;
          pert_en_n   = 1'b1;
          pert_sign_n = 1'b1;
          busy_n      = 1'b1;
          cnt_n       = SETTLE_LOAD;
        end
      end

      SETTLE_P, SETTLE_M: begin
        avg_clr_n = 1'b1;
        if (cnt == '0) begin
          state_n   = (state == SETTLE_P) ? AVG_P : AVG_M;
          avg_clr_n = 1'b0;
          cnt_n     = '0;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      // A result arriving on the final timeout cycle still counts as a capture.
      AVG_P, AVG_M: begin
        cnt_n = cnt + 1'b1;
        if (avg_rise) begin
          avg_clr_n = 1'b1;
          if (state == AVG_P) begin
            j_plus_n    = avg_data;
            pert_sign_n = 1'b0;
            state_n     = SETTLE_M;
            cnt_n       = SETTLE_LOAD;
          end else begin
            j_minus_n = avg_data;
            state_n   = CALC;
          end
        end else if (cnt == TIMEOUT_LAST) begin
          err_n     = 1'b1;
          pert_en_n = 1'b0;
          busy_n    = 1'b0;
          avg_clr_n = 1'b1;
          state_n   = IDLE;
        end
      end

      CALC: begin
        delta_n   = {1'b0, j_plus} - {1'b0, j_minus};
        valid_n   = 1'b1;
        pert_en_n = 1'b0;
        busy_n    = 1'b0;
        state_n   = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spgd_metric_sequencer.sv
// Directed and randomized bench for spgd_metric_sequencer; the averager is
// modelled by driving avg_done/avg_data directly with chosen latencies.
module tb_spgd_metric_sequencer;

  localparam int W = 12;
  localparam int S = 64;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   avg_data = '0;
  logic           avg_done = 1'b0;
  logic           avg_clr, pert_en, pert_sign, busy, valid, err;
  logic [W-1:0]   j_plus, j_minus;
  logic [W:0]     delta_j;

  int             passed = 0;
  int             total = 0;
  int             cyc = 0;
  logic [W-1:0]   exp_jp = '0;
  logic [W-1:0]   exp_jm = '0;
  logic [W:0]     exp_dj = '0;

  spgd_metric_sequencer #(
    .ADC_WIDTH(W), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .avg_data(avg_data), .avg_done(avg_done),
    .avg_clr(avg_clr), .pert_en(pert_en), .pert_sign(pert_sign), .busy(busy),
    .j_plus(j_plus), .j_minus(j_minus), .delta_j(delta_j), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Signed difference as plain integer arithmetic, wrapped into W+1 bits.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int d;
    d = int'(a) - int'(b);
    return (W+1)'(d);
  endfunction

  // One request. dm < 0 means the - side never answers (timeout).
  // hold leaves start high from the CALC cycle so the next call chains.
  task automatic measure(input logic [W-1:0] jp, input logic [W-1:0] jm, input int dp,
                         input int dm, input bit glitch, input bit stale, input bit hold);
    start = 1'b1;
    step();
    start = 1'b0;
    avg_done = 1'b0;
    chk("go_pert_en", 32'(pert_en), 1);
    chk("go_sign", 32'(pert_sign), 1);
    chk("go_busy", 32'(busy), 1);
    chk("go_clr", 32'(avg_clr), 1);
    for (int i = 2; i <= S; i++) begin
      step();
      avg_done = (glitch && i == 20) || (stale && i == S);
      avg_data = W'($urandom);
    end
    chk("settle_p_clr", 32'(avg_clr), 1);
    step();
    chk("avg_p_clr", 32'(avg_clr), 0);
    for (int k = 0; k <= dp; k++) begin
      if (k > 0) step();
      avg_done = (k == dp) || (stale && k < 3);
      avg_data = (k == dp) ? jp : W'($urandom);
      if (k == dp) chk("jp_hold", 32'(j_plus), 32'(exp_jp));
    end
    step();
    avg_done = 1'b0;
    exp_jp = jp;
    chk("jp_cap", 32'(j_plus), 32'(exp_jp));
    chk("sign_m", 32'(pert_sign), 0);
    chk("clr_settle_m", 32'(avg_clr), 1);
    chk("no_err_p", 32'(err), 0);
    repeat (S-1) step();
    chk("settle_m_clr", 32'(avg_clr), 1);
    step();
    chk("avg_m_clr", 32'(avg_clr), 0);
    if (dm < 0) begin
      repeat (T-1) step();
      chk("pre_to_err", 32'(err), 0);
      chk("pre_to_busy", 32'(busy), 1);
      step();
      chk("to_err", 32'(err), 1);
      chk("to_busy", 32'(busy), 0);
      chk("to_valid", 32'(valid), 0);
      chk("to_pert_en", 32'(pert_en), 0);
      chk("to_jp", 32'(j_plus), 32'(exp_jp));
      chk("to_jm", 32'(j_minus), 32'(exp_jm));
      chk("to_dj", 32'(delta_j), 32'(exp_dj));
      step();
      chk("to_err_end", 32'(err), 0);
    end else begin
      for (int k = 0; k <= dm; k++) begin
        if (k > 0) step();
        avg_done = (k == dm);
        avg_data = (k == dm) ? jm : W'($urandom);
        if (k == dm) chk("jm_hold", 32'(j_minus), 32'(exp_jm));
      end
      step();
      avg_done = 1'b0;
      if (hold) start = 1'b1;
      exp_jm = jm;
      exp_dj = model(exp_jp, exp_jm);
      chk("jm_cap", 32'(j_minus), 32'(exp_jm));
      chk("calc_busy", 32'(busy), 1);
      chk("calc_valid", 32'(valid), 0);
      chk("calc_err", 32'(err), 0);
      step();
      chk("valid", 32'(valid), 1);
      chk("dj", 32'(delta_j), 32'(exp_dj));
      chk("done_busy", 32'(busy), 0);
      chk("done_pert_en", 32'(pert_en), 0);
      chk("done_clr", 32'(avg_clr), 1);
      if (!hold) begin
        step();
        chk("valid_end", 32'(valid), 0);
        chk("idle_busy", 32'(busy), 0);
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_clr"}, 32'(avg_clr), 1);
    chk({tag, "_pert_en"}, 32'(pert_en), 0);
    chk({tag, "_sign"}, 32'(pert_sign), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_jp"}, 32'(j_plus), 0);
    chk({tag, "_jm"}, 32'(j_minus), 0);
    chk({tag, "_dj"}, 32'(delta_j), 0);
  endtask

  initial begin
    logic [W-1:0] rjp, rjm;
    int rdp, rdm;
    bit rstale;

    // Reset held with start high: nothing may leave the idle state.
    rst_n = 1'b0;
    start = 1'b1;
    repeat (3) step();
    check_reset_state("rst");
    rst_n = 1'b1;
    start = 1'b0;
    cyc = 0;
    repeat (5) step();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_pert_en", 32'(pert_en), 0);
    while (cyc < 10) step();

    // Nominal: start in cycle 10, glitch during settle, stale level into AVG_P.
    measure(12'h7FF, 12'h800, 6, 7, 1'b1, 1'b1, 1'b0);
    // Extremes with events on the first and last window cycles.
    measure(12'hFFF, 12'h000, 0, T-1, 1'b0, 1'b0, 1'b0);
    measure(12'h000, 12'hFFF, T-1, 0, 1'b0, 1'b0, 1'b1);
    // Chained start from the previous CALC.
    measure(12'h123, 12'h456, 3, 9, 1'b0, 1'b0, 1'b0);
    // - side never answers.
    measure(12'hABC, 12'h000, 2, -1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      rjp = W'($urandom);
      rjm = W'($urandom);
      rdp = $urandom_range(0, T-1);
      rdm = $urandom_range(0, T-1);
      rstale = (rdp >= 4) && ($urandom_range(0, 1) == 1);
      measure(rjp, rjm, rdp, rdm, 1'($urandom_range(0, 1)), rstale, n == 2);
    end

    // Asynchronous reset in the middle of AVG_M, then a fresh sequence.
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (S) step();
    avg_done = 1'b1;
    avg_data = 12'h5A5;
    step();
    avg_done = 1'b0;
    repeat (S + 3) step();
    #2 rst_n = 1'b0;
    #1;
    check_reset_state("mid_rst");
    exp_jp = '0;
    exp_jm = '0;
    exp_dj = '0;
    step();
    rst_n = 1'b1;
    step();
    chk("mid_rst_idle", 32'(busy), 0);
    rjp = W'($urandom);
    rjm = W'($urandom);
    measure(rjp, rjm, 5, 4, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spgd_metric_sequencer.md
# spgd_metric_sequencer

Downstream consumer of the ADC averager in the SPGD loop. Runs one two-sided perturbation measurement per request:
- apply the + perturbation, let the optics settle, collect one averaged metric J+;
- apply the − perturbation, settle, collect J−;
- output the signed difference ΔJ = J+ − J− for the gradient-update stage.

It also controls the averager: it holds the averager cleared while the optics settle and releases it only when a sample window should begin.

## Interface
Parameters:
- ADC_WIDTH, 12, width of the averaged metric from the averager.
- SETTLE_CYCLES, 64, number of cycles the averager is held cleared after each perturbation change (must be ≥1).
- TIMEOUT_CYCLES, 4096, maximum number of cycles to wait for an averager result before aborting (must exceed the averager's NUM_SAMPS).

Ports:
- CLK  in  1  single system clock (the ADC clock); everything is on its rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  measurement request; sampled only in IDLE.
- AVG_DATA  in  ADC_WIDTH  averaged metric from the averager (unsigned).
- AVG_DONE  in  1  averager completion flag; level or pulse, only its rising edge is used.
- AVG_CLR  out  1  high holds the averager cleared.
- PERT_EN  out  1  perturbation drive enable.
- PERT_SIGN  out  1  1 = + perturbation, 0 = − perturbation.
- BUSY  out  1  high in every state except IDLE.
- J_PLUS  out  ADC_WIDTH  last captured J+.
- J_MINUS  out  ADC_WIDTH  last captured J−.
- DELTA_J  out  ADC_WIDTH+1  signed two's-complement J_PLUS − J_MINUS.
- VALID  out  1  one-cycle strobe; DELTA_J is updated in the same cycle.
- ERR  out  1  one-cycle strobe on timeout.

## Operation
- States: IDLE, SETTLE_P, AVG_P, SETTLE_M, AVG_M, CALC.
- Edge detect: register AVG_DONE_d; the event is avg_rise = AVG_DONE & ~AVG_DONE_d, evaluated every cycle.
  - A stale high level on entry to AVG_P or AVG_M never counts as an event.
- IDLE:
  - AVG_CLR=1, PERT_EN=0.
  - START=1 → SETTLE_P; PERT_EN=1, PERT_SIGN=1, settle counter loaded with SETTLE_CYCLES−1.
- SETTLE_P:
  - AVG_CLR=1; counter decrements each cycle.
  - Counter at 0 → AVG_P; AVG_CLR=0, timeout counter cleared.
- AVG_P: timeout counter increments each cycle.
  - avg_rise → J_PLUS ← AVG_DATA, PERT_SIGN=0, → SETTLE_M (counter reloaded).
  - Otherwise, counter reaching TIMEOUT_CYCLES−1 → ERR=1, PERT_EN=0, → IDLE.
- SETTLE_M, AVG_M: identical to SETTLE_P and AVG_P, except an AVG_M event captures J_MINUS and moves to CALC.
- CALC (one cycle): DELTA_J ← {1'b0,J_PLUS} − {1'b0,J_MINUS}, VALID=1, PERT_EN=0, → IDLE.
- Arithmetic: the result always fits in ADC_WIDTH+1 bits, so there is no saturation.
  - Range is +(2^ADC_WIDTH−1) to −(2^ADC_WIDTH−1).
- Same-cycle event and timeout: an event on the final timeout cycle wins; capture proceeds and no ERR is raised.
- On timeout: J_PLUS, J_MINUS and DELTA_J keep their previous values and VALID is not raised.
- START outside IDLE is ignored.
  - START held high through CALC starts a new measurement on the first IDLE cycle.
- Reset mid-operation: immediate return to IDLE; all outputs go to their reset values, and any partial capture is discarded.

## Timing
- Reset values: state IDLE, AVG_CLR=1, PERT_EN=0, PERT_SIGN=0, BUSY=0, VALID=0, ERR=0, J_PLUS=J_MINUS=0, DELTA_J=0, AVG_DONE_d=0.
- All outputs are registered.
- START high at edge t:
  - PERT_EN=1, PERT_SIGN=1 and BUSY=1 from t+1.
  - AVG_CLR stays 1 for cycles t+1 … t+SETTLE_CYCLES and falls to 0 at t+SETTLE_CYCLES+1.
- avg_rise seen at edge r in AVG_P:
  - J_PLUS is valid and PERT_SIGN=0 from r+1.
  - AVG_CLR=1 from r+1 for SETTLE_CYCLES cycles.
- avg_rise seen at edge s in AVG_M:
  - J_MINUS is valid from s+1, when the state is CALC.
  - DELTA_J and VALID are asserted at s+2.
  - BUSY=0 and PERT_EN=0 from s+2.
- Timeout: ERR is asserted TIMEOUT_CYCLES cycles after AVG_CLR falls; BUSY=0 in that same cycle.

## Test plan
- Reset: hold RST=0 with START=1 → AVG_CLR=1, PERT_EN=0, BUSY=0, DELTA_J=0. Release → nothing happens until START is sampled in IDLE.
- Nominal (ADC_WIDTH=12, SETTLE_CYCLES=64, behavioural averager with 1024 samples): AVG_DATA=0x7FF on the + side and 0x800 on the − side → J_PLUS=0x7FF, J_MINUS=0x800, DELTA_J=0x1FFF (−1), single VALID pulse, PERT_SIGN sequence 1 then 0.
- Extremes: J+=0xFFF, J−=0x000 → DELTA_J=0x0FFF. J+=0x000, J−=0xFFF → DELTA_J=0x1001.
- Settle timing: assert START at cycle 10 → AVG_CLR falls at cycle 75. An AVG_DONE pulse during SETTLE_P is ignored. AVG_DONE held high across entry to AVG_P produces no capture until it falls and rises again.
- Timeout (TIMEOUT_CYCLES=16): never raise AVG_DONE in AVG_M → ERR pulse 16 cycles after AVG_CLR falls, no VALID, J_PLUS retains the new value, J_MINUS and DELTA_J retain their old values. An edge on the 16th cycle → capture, no ERR.
- Reset mid-AVG_M, then START again → a fresh full sequence that uses no stale J_PLUS in DELTA_J.
